// File: rtl/vga_pkg.sv
// Shared VGA raster constants, position width and frame-size helpers used by the
// timing generator and the downstream position-to-block adapter.
package vga_pkg;

   localparam int POS_W   = 10;
   localparam int POS_MAX = 1 << POS_W;

   localparam int DEF_H_VISIBLE = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;
   localparam int DEF_V_VISIBLE = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic video_on;
   } vga_sync_t;

   function automatic int h_total(input int visible, input int front, input int sync, input int back);
      return visible + front + sync + back;
   endfunction

   function automatic int v_total(input int visible, input int front, input int sync, input int back);
      return visible + front + sync + back;
   endfunction

endpackage

// File: rtl/vga_pixel_div.sv
// Pixel-enable divider: wraps every CLK_DIV clocks; pixelTick is the registered wrap,
// wrap is the same-cycle strobe that lets the counters update on the edge pixelTick rises.
module vga_pixel_div #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   output logic pixelTick,
   output logic wrap
);

   localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

   logic [3:0] div_cnt_r;

   if (CLK_DIV < 1 || CLK_DIV > 15) begin : g_div_range
      $error("vga_pixel_div: CLK_DIV must be in 1..15");
   end

   // Wrap strobe on the last count of the pixel period
   always_comb begin
      if (div_cnt_r == DIV_LAST) begin
         wrap = 1'b1;
      end else begin
         wrap = 1'b0;
      end
   end

   // Divider counter and registered pixel tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_r <= 4'd0;
         pixelTick <= 1'b0;
      end else begin
         pixelTick <= wrap;
         if (wrap) begin
            div_cnt_r <= 4'd0;
         end else begin
            div_cnt_r <= div_cnt_r + 4'd1;
         end
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (default 640x480@60). Defining VGA_SYNC_DELAY_EN adds one
// pixel-tick delay stage on hsync/vsync/videoOn to match a synchronous video-memory read.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_VISIBLE = DEF_H_VISIBLE,
   parameter int H_FRONT   = DEF_H_FRONT,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BACK    = DEF_H_BACK,
   parameter int V_VISIBLE = DEF_V_VISIBLE,
   parameter int V_FRONT   = DEF_V_FRONT,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BACK    = DEF_V_BACK,
   parameter int CLK_DIV   = 2,
   parameter bit SYNC_POL  = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             pixelTick,
   output logic [POS_W-1:0] widthVgaPos,
   output logic [POS_W-1:0] heightVgaPos,
   output logic             hsync,
   output logic             vsync,
   output logic             videoOn,
   output logic             frameStart
);

   localparam int H_TOTAL    = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
   localparam int V_TOTAL    = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
   localparam int H_SYNC_BEG = H_VISIBLE + H_FRONT;
   localparam int H_SYNC_END = H_VISIBLE + H_FRONT + H_SYNC;
   localparam int V_SYNC_BEG = V_VISIBLE + V_FRONT;
   localparam int V_SYNC_END = V_VISIBLE + V_FRONT + V_SYNC;

   localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_TOTAL - 1);
   localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_TOTAL - 1);
   localparam logic [POS_W-1:0] POS_ZERO = {POS_W{1'b0}};
   localparam logic [POS_W-1:0] POS_ONE  = {{(POS_W-1){1'b0}}, 1'b1};
   localparam vga_sync_t SYNC_IDLE = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, video_on: 1'b0};

   if (H_TOTAL > POS_MAX || V_TOTAL > POS_MAX) begin : g_size_check
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the position counter range");
   end

   logic             adv_s;
   logic [POS_W-1:0] h_cnt_r;
   logic [POS_W-1:0] v_cnt_r;
   logic [POS_W-1:0] h_next_s;
   logic [POS_W-1:0] v_next_s;
   vga_sync_t        sync_next_s;
   vga_sync_t        sync_r;
   vga_sync_t        sync_out_s;
   logic             frame_next_s;
   logic             frame_start_r;

   vga_pixel_div #(
      .CLK_DIV (CLK_DIV)
   ) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .pixelTick (pixelTick),
      .wrap      (adv_s)
   );

   // Next raster position; the reset value (last, last) makes the first tick land on (0,0)
   always_comb begin
      h_next_s = h_cnt_r;
      v_next_s = v_cnt_r;
      if (adv_s) begin
         if (h_cnt_r == H_LAST) begin
            h_next_s = POS_ZERO;
            if (v_cnt_r == V_LAST) begin
               v_next_s = POS_ZERO;
            end else begin
               v_next_s = v_cnt_r + POS_ONE;
            end
         end else begin
            h_next_s = h_cnt_r + POS_ONE;
         end
      end else begin
         h_next_s = h_cnt_r;
         v_next_s = v_cnt_r;
      end
   end

   // Sync/visible decode from the next position so flags align with the counters
   always_comb begin
      sync_next_s.hsync    = ((int'(h_next_s) >= H_SYNC_BEG) && (int'(h_next_s) < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
      sync_next_s.vsync    = ((int'(v_next_s) >= V_SYNC_BEG) && (int'(v_next_s) < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
      sync_next_s.video_on = (int'(h_next_s) < H_VISIBLE) && (int'(v_next_s) < V_VISIBLE);
      frame_next_s         = adv_s && (h_next_s == POS_ZERO) && (v_next_s == POS_ZERO);
   end

   // Position counters and decoded flags; frameStart is a single-clock pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt_r       <= H_LAST;
         v_cnt_r       <= V_LAST;
         sync_r        <= SYNC_IDLE;
         frame_start_r <= 1'b0;
      end else begin
         frame_start_r <= frame_next_s;
         if (adv_s) begin
            h_cnt_r <= h_next_s;
            v_cnt_r <= v_next_s;
            sync_r  <= sync_next_s;
         end
      end
   end

`ifdef VGA_SYNC_DELAY_EN
   vga_sync_t sync_dly_r;

   // One-tick delay stage for sync and visible flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_dly_r <= SYNC_IDLE;
      end else if (adv_s) begin
         sync_dly_r <= sync_r;
      end
   end

   assign sync_out_s = sync_dly_r;
`else
   assign sync_out_s = sync_r;
`endif

   assign widthVgaPos  = h_cnt_r;
   assign heightVgaPos = v_cnt_r;
   assign hsync        = sync_out_s.hsync;
   assign vsync        = sync_out_s.vsync;
   assign videoOn      = sync_out_s.video_on;
   assign frameStart   = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing, CLK_DIV=1, and a reduced
// active-high-sync raster small enough to run whole frames.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_DELAY_EN
   localparam bit DLY = 1'b1;
`else
   localparam bit DLY = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       pixelTick, hsync, vsync, videoOn, frameStart;
   logic [9:0] widthVgaPos, heightVgaPos;
   logic       f_pixelTick, f_hsync, f_vsync, f_videoOn, f_frameStart;
   logic [9:0] f_h, f_v;
   logic       s_pixelTick, s_hsync, s_vsync, s_videoOn, s_frameStart;
   logic [9:0] s_h, s_v;

   int chk_cnt = 0;
   int pass_cnt = 0;

   vga_timing_gen u_dut (
      .clk(clk), .rst_n(rst_n), .pixelTick(pixelTick), .widthVgaPos(widthVgaPos),
      .heightVgaPos(heightVgaPos), .hsync(hsync), .vsync(vsync), .videoOn(videoOn),
      .frameStart(frameStart)
   );

   vga_timing_gen #(.CLK_DIV(1)) u_fast (
      .clk(clk), .rst_n(rst_n), .pixelTick(f_pixelTick), .widthVgaPos(f_h),
      .heightVgaPos(f_v), .hsync(f_hsync), .vsync(f_vsync), .videoOn(f_videoOn),
      .frameStart(f_frameStart)
   );

   // 15 x 11 raster: hsync h=10..12, vsync v=7..8, visible 8 x 6, active-high sync
   vga_timing_gen #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
      .CLK_DIV(3), .SYNC_POL(1'b1)
   ) u_small (
      .clk(clk), .rst_n(rst_n), .pixelTick(s_pixelTick), .widthVgaPos(s_h),
      .heightVgaPos(s_v), .hsync(s_hsync), .vsync(s_vsync), .videoOn(s_videoOn),
      .frameStart(s_frameStart)
   );

   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic exp_vo;
      exp_vo = ~DLY;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_cnt++; if (widthVgaPos !== 10'd799) $display("FAIL reset_h: got %0d want 799", widthVgaPos); else pass_cnt++;
      chk_cnt++; if (heightVgaPos !== 10'd524) $display("FAIL reset_v: got %0d want 524", heightVgaPos); else pass_cnt++;
      chk_cnt++; if ({hsync, vsync} !== 2'b11) $display("FAIL reset_sync: got %b want 11", {hsync, vsync}); else pass_cnt++;
      chk_cnt++; if ({videoOn, frameStart, pixelTick} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {videoOn, frameStart, pixelTick}); else pass_cnt++;
      rst_n = 1'b1;
      @(negedge clk);
      chk_cnt++; if ({pixelTick, widthVgaPos} !== {1'b0, 10'd799}) $display("FAIL first_clk: tick=%b h=%0d want 0/799", pixelTick, widthVgaPos); else pass_cnt++;
      @(negedge clk);
      chk_cnt++; if ({widthVgaPos, heightVgaPos} !== 20'd0) $display("FAIL first_tick_pos: got (%0d,%0d) want (0,0)", widthVgaPos, heightVgaPos); else pass_cnt++;
      chk_cnt++; if ({pixelTick, frameStart, hsync, vsync} !== 4'b1111) $display("FAIL first_tick_flags: got %b want 1111", {pixelTick, frameStart, hsync, vsync}); else pass_cnt++;
      chk_cnt++; if (videoOn !== exp_vo) $display("FAIL first_tick_video: got %b want %b", videoOn, exp_vo); else pass_cnt++;
      @(negedge clk);
      chk_cnt++; if ({pixelTick, frameStart, widthVgaPos} !== {2'b00, 10'd0}) $display("FAIL hold: tick=%b fs=%b h=%0d want 0/0/0", pixelTick, frameStart, widthVgaPos); else pass_cnt++;
      @(negedge clk);
      chk_cnt++; if (widthVgaPos !== 10'd1) $display("FAIL second_tick_h: got %0d want 1", widthVgaPos); else pass_cnt++;
   endtask

   task automatic test_line();
      int hs_cnt, hs_first, hs_last, vo_fall, period, bad;
      logic [9:0] exp_h;
      apply_reset();
      repeat (2) @(negedge clk);
      hs_cnt = 0; hs_first = -1; hs_last = -1; vo_fall = -1; period = -1; bad = 0; exp_h = 10'd0;
      for (int c = 1; c <= 1600; c++) begin
         @(negedge clk);
         if (pixelTick !== ((c % 2) == 0)) bad++;
         if ((c % 2) == 0) begin
            exp_h = (exp_h == 10'd799) ? 10'd0 : exp_h + 10'd1;
            if (hsync === 1'b0) begin
               hs_cnt++;
               if (hs_first < 0) hs_first = int'(widthVgaPos);
               hs_last = int'(widthVgaPos);
            end
            if (videoOn === 1'b0 && vo_fall < 0) vo_fall = int'(widthVgaPos);
            if (widthVgaPos === 10'd0 && period < 0) period = c;
         end
         if (widthVgaPos !== exp_h) bad++;
      end
      chk_cnt++; if (bad != 0) $display("FAIL line_seq: %0d bad samples want 0", bad); else pass_cnt++;
      chk_cnt++; if (hs_cnt != 96) $display("FAIL hsync_width: got %0d want 96", hs_cnt); else pass_cnt++;
      chk_cnt++; if (hs_first != 656 + int'(DLY)) $display("FAIL hsync_first: got %0d want %0d", hs_first, 656 + int'(DLY)); else pass_cnt++;
      chk_cnt++; if (hs_last != 751 + int'(DLY)) $display("FAIL hsync_last: got %0d want %0d", hs_last, 751 + int'(DLY)); else pass_cnt++;
      chk_cnt++; if (vo_fall != 640 + int'(DLY)) $display("FAIL video_fall: got %0d want %0d", vo_fall, 640 + int'(DLY)); else pass_cnt++;
      chk_cnt++; if (period != 1600) $display("FAIL line_period: got %0d want 1600", period); else pass_cnt++;
      chk_cnt++; if ({heightVgaPos, vsync} !== {10'd1, 1'b1}) $display("FAIL line_end: v=%0d vsync=%b want 1/1", heightVgaPos, vsync); else pass_cnt++;
   endtask

   task automatic test_frame();
      int fs_n, fs1, fs2, vo_n, hs_n, vs_n, vs_first, vs_last, h_max, v_max, bad;
      apply_reset();
      fs_n = 0; fs1 = -1; fs2 = -1; vo_n = 0; hs_n = 0; vs_n = 0;
      vs_first = -1; vs_last = -1; h_max = 0; v_max = 0; bad = 0;
      for (int c = 1; c <= 1000; c++) begin
         @(negedge clk);
         if (s_frameStart === 1'b1) begin
            fs_n++;
            if (fs_n == 1) fs1 = c;
            else if (fs_n == 2) fs2 = c;
         end
         if (s_pixelTick === 1'b1 && c >= 3 && c < 498) begin
            if (s_videoOn === 1'b1) vo_n++;
            if (s_hsync === 1'b1) hs_n++;
            if (s_vsync === 1'b1) begin
               vs_n++;
               if (vs_first < 0) vs_first = int'(s_v);
               vs_last = int'(s_v);
            end
            if (int'(s_h) > h_max) h_max = int'(s_h);
            if (int'(s_v) > v_max) v_max = int'(s_v);
            if (s_frameStart !== (s_h == 10'd0 && s_v == 10'd0)) bad++;
         end
      end
      chk_cnt++; if (fs_n != 3) $display("FAIL frame_pulses: got %0d want 3", fs_n); else pass_cnt++;
      chk_cnt++; if (fs1 != 3) $display("FAIL frame_first: got clk %0d want 3", fs1); else pass_cnt++;
      chk_cnt++; if (fs2 - fs1 != 495) $display("FAIL frame_period: got %0d want 495", fs2 - fs1); else pass_cnt++;
      chk_cnt++; if (vo_n != 48) $display("FAIL frame_video: got %0d want 48", vo_n); else pass_cnt++;
      chk_cnt++; if (hs_n != 33) $display("FAIL frame_hsync: got %0d want 33", hs_n); else pass_cnt++;
      chk_cnt++; if (vs_n != 30) $display("FAIL frame_vsync: got %0d want 30", vs_n); else pass_cnt++;
      chk_cnt++; if (vs_first != 7 || vs_last != 8 + int'(DLY)) $display("FAIL vsync_lines: got %0d..%0d want 7..%0d", vs_first, vs_last, 8 + int'(DLY)); else pass_cnt++;
      chk_cnt++; if (h_max != 14 || v_max != 10) $display("FAIL frame_wrap: got max (%0d,%0d) want (14,10)", h_max, v_max); else pass_cnt++;
      chk_cnt++; if (bad != 0) $display("FAIL frame_start_pos: %0d bad want 0", bad); else pass_cnt++;
   endtask

   task automatic test_clkdiv1();
      int bad;
      apply_reset();
      @(negedge clk);
      chk_cnt++; if ({f_pixelTick, f_frameStart, f_h, f_v} !== {2'b11, 20'd0}) $display("FAIL div1_first: tick=%b fs=%b (%0d,%0d) want 1/1 (0,0)", f_pixelTick, f_frameStart, f_h, f_v); else pass_cnt++;
      bad = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (f_pixelTick !== 1'b1 || f_h !== 10'(i)) bad++;
      end
      chk_cnt++; if (bad != 0) $display("FAIL div1_run: %0d bad want 0", bad); else pass_cnt++;
      chk_cnt++; if ({f_h, f_frameStart} !== {10'd10, 1'b0}) $display("FAIL div1_end: h=%0d fs=%b want 10/0", f_h, f_frameStart); else pass_cnt++;
   endtask

   task automatic test_mid_reset();
      bit found;
      apply_reset();
      found = 1'b0;
      for (int c = 0; c < 4000 && !found; c++) begin
         @(negedge clk);
         if (widthVgaPos === 10'd300 && heightVgaPos === 10'd1) found = 1'b1;
      end
      chk_cnt++; if (!found) $display("FAIL mid_reach: got timeout want (300,1)"); else pass_cnt++;
      chk_cnt++; if ({pixelTick, videoOn} !== 2'b11) $display("FAIL mid_pre: tick/video=%b want 11", {pixelTick, videoOn}); else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      chk_cnt++; if ({widthVgaPos, heightVgaPos} !== {10'd799, 10'd524}) $display("FAIL mid_rst_pos: got (%0d,%0d) want (799,524)", widthVgaPos, heightVgaPos); else pass_cnt++;
      chk_cnt++; if ({hsync, vsync, videoOn, pixelTick} !== 4'b1100) $display("FAIL mid_rst_flags: got %b want 1100", {hsync, vsync, videoOn, pixelTick}); else pass_cnt++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk_cnt++; if ({widthVgaPos, heightVgaPos, frameStart} !== {20'd0, 1'b1}) $display("FAIL mid_restart: (%0d,%0d) fs=%b want (0,0) 1", widthVgaPos, heightVgaPos, frameStart); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_line();
      test_frame();
      test_clkdiv1();
      test_mid_reset();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
